ext_irq_ctrl: RTL and testbench

// - External interrupt controller feeding the core's machine-external interrupt line.
// - Collects NUM_SRC peripheral requests and keeps a pending bit per source.
// - Asserts meip_o toward the CSR unit and consumes the CSR unit's ack pulse to claim the winning source.
// - Software sees it as four memory-mapped words (ENABLE, PENDING, CLAIM, COMPLETE) on the data bus.

---
 rtl/ext_irq_ctrl_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 27 ++
 rtl/ext_irq_ctrl.sv | 158 +++++++++++++++
 tb/tb_ext_irq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_ctrl_pkg.sv
// Shared definitions for the external interrupt controller.
//   - ID_W      : width of an interrupt ID (IDs 1..31, 0 = none)
//   - NO_IRQ    : the "no interrupt" ID
//   - REG_*     : word selects on bus_addr_i[3:2]
//   - irq_state_e : controller FSM states
package ext_irq_ctrl_pkg;

  localparam int unsigned ID_W = 5;

  localparam logic [ID_W-1:0] NO_IRQ = '0;

  localparam logic [1:0] REG_ENABLE   = 2'd0;
  localparam logic [1:0] REG_PENDING  = 2'd1;
  localparam logic [1:0] REG_CLAIM    = 2'd2;
  localparam logic [1:0] REG_COMPLETE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
//   req   : request vector, bit k maps to ID k+1
//   valid : any request present
//   id    : ID of the lowest-index request, NO_IRQ when none
module irq_prio_enc
  import ext_irq_ctrl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = 1'b0;
    id    = NO_IRQ;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller driving the machine-external interrupt line.
// Collects NUM_SRC requests into pending bits, raises meip_o for the
// lowest-index enabled pending source, claims it on the rising edge of ack_i
// and releases it on a matching COMPLETE write.
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   irq_src_i        : raw requests (source k -> ID k+1)
//   ack_i            : claim strobe from the CSR unit (rising edge used)
//   meip_o           : registered interrupt request
//   bus_addr_i       : byte address, [3:2] = ENABLE/PENDING/CLAIM/COMPLETE
//   bus_wdata_i      : write data
//   bus_wen_i        : write strobe
//   bus_ren_i        : read strobe
//   bus_rdata_o      : registered read data, valid the cycle after bus_ren_i
//   claim_id_o       : currently claimed ID (0 = none)
module ext_irq_ctrl
  import ext_irq_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_SRC   = 8,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = 8'hFF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               ack_i,
  output logic               meip_o,
  input  logic [3:0]         bus_addr_i,
  input  logic [31:0]        bus_wdata_i,
  input  logic               bus_wen_i,
  input  logic               bus_ren_i,
  output logic [31:0]        bus_rdata_o,
  output logic [ID_W-1:0]    claim_id_o
);

  logic [NUM_SRC-1:0] sync1_q, sync2_q, dly_q;
  logic [NUM_SRC-1:0] pending_q, pending_d, enable_q;
  logic [NUM_SRC-1:0] set_vec, eligible, clr_w1c, clr_claim;
  logic               ack_q, ack_rise;
  irq_state_e         state_q, state_d;
  logic               meip_q, meip_d;
  logic               in_service_q, in_service_d;
  logic [ID_W-1:0]    claim_q, claim_d;
  logic               claim_take;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_enable, wr_pending, wr_complete, complete_hit;
  logic               unused_bits;

  assign unused_bits = ^{bus_addr_i[1:0], bus_wdata_i[31:NUM_SRC]};

  assign wr_enable   = bus_wen_i && (bus_addr_i[3:2] == REG_ENABLE);
  assign wr_pending  = bus_wen_i && (bus_addr_i[3:2] == REG_PENDING);
  assign wr_complete = bus_wen_i && (bus_addr_i[3:2] == REG_COMPLETE);
  assign complete_hit = wr_complete && in_service_q &&
                        (bus_wdata_i[ID_W-1:0] == claim_q);

  assign ack_rise = ack_i && !ack_q;

  // Edge sources fire on a synced 0->1, level sources on every synced high cycle.
  assign set_vec  = (sync2_q & ~dly_q & EDGE_MASK) | (sync2_q & ~EDGE_MASK);
  assign eligible = pending_q & enable_q;
  assign clr_w1c  = wr_pending ? bus_wdata_i[NUM_SRC-1:0] : '0;

  // Set is OR-ed after clearing so a new request in the clear cycle survives.
  assign pending_d = (pending_q & ~clr_w1c & ~clr_claim) | set_vec;

  irq_prio_enc #(
    .N (NUM_SRC)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    state_d      = state_q;
    claim_d      = claim_q;
    in_service_d = in_service_q;
    claim_take   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!win_valid) begin
          state_d = ST_IDLE;
        end else if (ack_rise) begin
          claim_d      = win_id;
          in_service_d = 1'b1;
          claim_take   = 1'b1;
          state_d      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (complete_hit) begin
          claim_d      = NO_IRQ;
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    meip_d = (state_d == ST_REQ);
  end

  always_comb begin
    clr_claim = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      clr_claim[i] = claim_take && (win_id == ID_W'(i + 1));
    end
  end

  // Read mux samples current register values, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_ren_i) begin
      unique case (bus_addr_i[3:2])
        REG_ENABLE:  rdata_d = 32'(enable_q);
        REG_PENDING: rdata_d = 32'(pending_q);
        REG_CLAIM:   rdata_d = 32'(claim_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      dly_q        <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      ack_q        <= 1'b0;
      state_q      <= ST_IDLE;
      meip_q       <= 1'b0;
      in_service_q <= 1'b0;
      claim_q      <= NO_IRQ;
      rdata_q      <= '0;
    end else begin
      sync1_q      <= irq_src_i;
      sync2_q      <= sync1_q;
      dly_q        <= sync2_q;
      pending_q    <= pending_d;
      if (wr_enable) enable_q <= bus_wdata_i[NUM_SRC-1:0];
      ack_q        <= ack_i;
      state_q      <= state_d;
      meip_q       <= meip_d;
      in_service_q <= in_service_d;
      claim_q      <= claim_d;
      rdata_q      <= rdata_d;
    end
  end

  assign meip_o      = meip_q;
  assign bus_rdata_o = rdata_q;
  assign claim_id_o  = claim_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl (source 0 configured as level).
module tb_ext_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        ack;
  logic        meip;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic [4:0]  claim_id;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] A_ENABLE   = 4'h0;
  localparam logic [3:0] A_PENDING  = 4'h4;
  localparam logic [3:0] A_CLAIM    = 4'h8;
  localparam logic [3:0] A_COMPLETE = 4'hC;

  ext_irq_ctrl #(
    .NUM_SRC   (8),
    .EDGE_MASK (8'hFE)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .irq_src_i   (irq),
    .ack_i       (ack),
    .meip_o      (meip),
    .bus_addr_i  (addr),
    .bus_wdata_i (wdata),
    .bus_wen_i   (wen),
    .bus_ren_i   (ren),
    .bus_rdata_o (rdata),
    .claim_id_o  (claim_id)
  );

  initial forever #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick(1);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    tick(1);
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic pulse_src(input int idx);
    irq[idx] = 1'b1;
    tick(1);
    irq[idx] = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = '0; ack = 1'b0; wen = 1'b0; ren = 1'b0;
    addr = '0; wdata = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; irq = 8'hFF; ack = 1'b0; wen = 1'b0; ren = 1'b0;
    addr = '0; wdata = '0;
    tick(3);
    n_checks++; if (meip !== 1'b0) begin n_fail++; $display("FAIL reset_meip: got %b expected 0", meip); end
    n_checks++; if (claim_id !== 5'd0) begin n_fail++; $display("FAIL reset_claim: got %0d expected 0", claim_id); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    irq = '0; rst = 1'b0;
    tick(1);
    bus_read(A_ENABLE, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_enable: got %h expected 0", d); end
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", d); end
    bus_read(A_CLAIM, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_claimreg: got %h expected 0", d); end
  endtask

  task automatic test_single_edge();
    logic [31:0] d;
    do_reset();
    bus_write(A_ENABLE, 32'h04);
    pulse_src(2);
    tick(2);
    n_checks++; if (meip !== 1'b0) begin n_fail++; $display("FAIL edge_latency3: got %b expected 0", meip); end
    tick(1);
    n_checks++; if (meip !== 1'b1) begin n_fail++; $display("FAIL edge_latency4: got %b expected 1", meip); end
    pulse_ack();
    n_checks++; if (meip !== 1'b0) begin n_fail++; $display("FAIL edge_meip_after_ack: got %b expected 0", meip); end
    bus_read(A_CLAIM, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL edge_claim: got %h expected 3", d); end
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_pending: got %h expected 0", d); end
    bus_write(A_COMPLETE, 32'd3);
    n_checks++; if (claim_id !== 5'd0) begin n_fail++; $display("FAIL edge_complete: got %0d expected 0", claim_id); end
    tick(2);
    n_checks++; if (meip !== 1'b0) begin n_fail++; $display("FAIL edge_idle_meip: got %b expected 0", meip); end
    bus_read(A_COMPLETE, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL complete_reads0: got %h expected 0", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    do_reset();
    bus_write(A_ENABLE, 32'hFF);
    irq[5] = 1'b1; irq[1] = 1'b1;
    tick(1);
    irq = '0;
    tick(3);
    n_checks++; if (meip !== 1'b1) begin n_fail++; $display("FAIL prio_meip: got %b expected 1", meip); end
    ack = 1'b1;  // held high across the whole release: must claim only once
    tick(1);
    n_checks++; if (claim_id !== 5'd2) begin n_fail++; $display("FAIL prio_first: got %0d expected 2", claim_id); end
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h20) begin n_fail++; $display("FAIL prio_pending: got %h expected 20", d); end
    bus_write(A_COMPLETE, 32'd2);
    tick(1);
    n_checks++; if (meip !== 1'b1) begin n_fail++; $display("FAIL prio_reassert: got %b expected 1", meip); end
    tick(1);
    n_checks++; if (claim_id !== 5'd0) begin n_fail++; $display("FAIL ack_held_once: got %0d expected 0", claim_id); end
    ack = 1'b0;
    tick(1);
    pulse_ack();
    n_checks++; if (claim_id !== 5'd6) begin n_fail++; $display("FAIL prio_second: got %0d expected 6", claim_id); end
    bus_write(A_COMPLETE, 32'd6);
    n_checks++; if (claim_id !== 5'd0) begin n_fail++; $display("FAIL prio_release: got %0d expected 0", claim_id); end
  endtask

  task automatic test_wrong_complete();
    do_reset();
    bus_write(A_ENABLE, 32'h04);
    pulse_src(2);
    tick(3);
    pulse_ack();
    n_checks++; if (claim_id !== 5'd3) begin n_fail++; $display("FAIL wrong_claim: got %0d expected 3", claim_id); end
    bus_write(A_COMPLETE, 32'd4);
    tick(2);
    n_checks++; if (meip !== 1'b0) begin n_fail++; $display("FAIL wrong_meip: got %b expected 0", meip); end
    n_checks++; if (claim_id !== 5'd3) begin n_fail++; $display("FAIL wrong_kept: got %0d expected 3", claim_id); end
    bus_write(A_COMPLETE, 32'd3);
    n_checks++; if (claim_id !== 5'd0) begin n_fail++; $display("FAIL wrong_release: got %0d expected 0", claim_id); end
  endtask

  task automatic test_masking();
    logic [31:0] d;
    do_reset();
    irq[0] = 1'b1;
    bus_write(A_ENABLE, 32'h01);
    tick(3);
    n_checks++; if (meip !== 1'b1) begin n_fail++; $display("FAIL mask_meip_on: got %b expected 1", meip); end
    bus_write(A_ENABLE, 32'h00);
    tick(1);
    n_checks++; if (meip !== 1'b0) begin n_fail++; $display("FAIL mask_meip_off: got %b expected 0", meip); end
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL mask_pending: got %h expected 01", d); end
    bus_write(A_ENABLE, 32'h01);
    tick(1);
    n_checks++; if (meip !== 1'b1) begin n_fail++; $display("FAIL mask_reenable: got %b expected 1", meip); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    do_reset();
    irq[0] = 1'b1;
    bus_write(A_ENABLE, 32'h01);
    tick(3);
    pulse_ack();
    n_checks++; if (claim_id !== 5'd1) begin n_fail++; $display("FAIL level_claim: got %0d expected 1", claim_id); end
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL level_reset_pend: got %h expected 01", d); end
    irq[0] = 1'b0;
    bus_write(A_COMPLETE, 32'd1);
    tick(1);
    n_checks++; if (meip !== 1'b1) begin n_fail++; $display("FAIL level_rerequest: got %b expected 1", meip); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    do_reset();
    pulse_src(2);
    tick(3);
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL w1c_before: got %h expected 04", d); end
    bus_write(A_PENDING, 32'h04);
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL w1c_clear: got %h expected 00", d); end
    irq[2] = 1'b1;
    tick(1);
    irq[2] = 1'b0;
    tick(1);
    bus_write(A_PENDING, 32'h04);
    bus_read(A_PENDING, d);
    n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL w1c_race: got %h expected 04", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    bus_write(A_ENABLE, 32'h55);
    addr = A_ENABLE; wdata = 32'hAA; wen = 1'b1; ren = 1'b1;
    tick(1);
    wen = 1'b0; ren = 1'b0;
    n_checks++; if (rdata !== 32'h55) begin n_fail++; $display("FAIL rw_prewrite: got %h expected 55", rdata); end
    bus_read(A_ENABLE, d);
    n_checks++; if (d !== 32'hAA) begin n_fail++; $display("FAIL rw_postwrite: got %h expected AA", d); end
    bus_write(A_ENABLE, 32'hFFFF_FFFF);
    bus_read(A_ENABLE, d);
    n_checks++; if (d !== 32'hFF) begin n_fail++; $display("FAIL enable_upper: got %h expected FF", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    bus_write(A_ENABLE, 32'h04);
    pulse_src(2);
    tick(3);
    pulse_ack();
    bus_read(A_CLAIM, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL mid_claim: got %h expected 3", d); end
    rst = 1'b1;
    #1;
    n_checks++; if (claim_id !== 5'd0) begin n_fail++; $display("FAIL mid_claim_rst: got %0d expected 0", claim_id); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rdata_rst: got %h expected 0", rdata); end
    tick(1);
    rst = 1'b0;
    tick(1);
    bus_read(A_ENABLE, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_enable_rst: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_wrong_complete();
    test_masking();
    test_level();
    test_w1c_race();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
